// File: rtl/parity_frame_rx.sv
// parity_frame_rx: receiver for 4-bit even-parity serial frames.
// Frame format, one bit per din_valid cycle: start(0), A, B, C, D, P, stop(1).
// The recovered nibble and its error flags are offered on a one-entry valid/ready
// holding register. If a frame completes while that register is still full, the
// new frame is dropped and the sticky overrun flag is set.
// Optional feature: define PARITY_ERR_CNT_EN to build the saturating err_count
// counter. Without the macro, err_count is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a start bit (din == 0)
// DATA   | shifting in message bits A..D
// PARITY | waiting for the parity bit P
// STOP   | waiting for the stop bit; the frame completes here
module parity_frame_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [3:0]       out_msg,
  output logic             out_par_err,
  output logic             out_frm_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] shreg;
  logic [1:0] bit_idx;
  logic       par_bit;
  logic       frame_done;
  logic       par_err;
  logic       frm_err;
  logic       load;
  logic       drain;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, frame-completion detect and holding-register handshake
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    par_err    = ^shreg ^ par_bit;
    frm_err    = ~din;
    drain      = out_valid && out_ready;
    load       = 1'b0;
    if (din_valid) begin
      case (state)
        IDLE:    if (!din) state_nxt = DATA;
        DATA:    if (bit_idx == 2'd3) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // A frame can be loaded into an empty register, or into one that is being drained this cycle
    load = frame_done && (!out_valid || out_ready);
  end

  // Deserialiser: shift register, bit index and parity bit capture
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else if (din_valid) begin
      case (state)
        IDLE:   bit_idx <= '0;
        DATA: begin
          shreg   <= {shreg[2:0], din};
          bit_idx <= bit_idx + 2'd1;
        end
        PARITY: par_bit <= din;
        default: ;
      endcase
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_msg     <= '0;
      out_par_err <= 1'b0;
      out_frm_err <= 1'b0;
      out_valid   <= 1'b0;
    end else if (load) begin
      out_msg     <= shreg;
      out_par_err <= par_err;
      out_frm_err <= frm_err;
      out_valid   <= 1'b1;
    end else if (drain) begin
      out_valid   <= 1'b0;
    end
  end

  // Sticky overrun: a completed frame found the holding register full and not draining
  always_ff @(posedge clk) begin
    if (rst)                                   overrun <= 1'b0;
    else if (frame_done && out_valid && !out_ready) overrun <= 1'b1;
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating error counter; dropped frames are counted too
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= '0;
    else if (frame_done && (par_err || frm_err) && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: stimulus pushes the expected frame
// results, and a negedge monitor pops and compares them on each handshake.
module tb_parity_frame_rx;

`ifdef PARITY_ERR_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          din_valid;
  logic [3:0]    out_msg;
  logic          out_par_err;
  logic          out_frm_err;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic [CW-1:0] err_count;

  int n_pass  = 0;
  int n_total = 0;
  int exp_err = 0;

  logic [5:0] exp_q[$];

  parity_frame_rx #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .out_msg(out_msg), .out_par_err(out_par_err), .out_frm_err(out_frm_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_transfer: got msg %0h expected no transfer at %0t", out_msg, $time);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("sb_msg", int'(out_msg), int'(e[5:2]));
        chk("sb_par_err", int'(out_par_err), int'(e[1]));
        chk("sb_frm_err", int'(out_frm_err), int'(e[0]));
      end
    end
  end

  task automatic push(input logic [3:0] msg, input logic par, input logic frm);
    exp_q.push_back({msg, par, frm});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic chk_err_count();
`ifdef PARITY_ERR_CNT_EN
    chk("err_count", int'(err_count), exp_err);
`else
    chk("err_count_tied", int'(err_count), 0);
`endif
  endtask

  // f[6]=start, f[5:2]=A..D, f[1]=P, f[0]=stop
  task automatic send_frame(input logic [6:0] f, input int stall, input bit quiet,
                            input bit ready_at_stop);
    for (int i = 6; i >= 0; i--) begin
      if (i == 0 && ready_at_stop) out_ready = 1'b1;
      send_bit(f[i]);
      if (i > 0) begin
        if (stall > 0) idle(stall);
        if (quiet) chk("no_early_valid", int'(out_valid), 0);
      end
    end
    if ((^f[5:1]) || !f[0]) exp_err = (exp_err < (1 << CW) - 1) ? exp_err + 1 : exp_err;
    chk_err_count();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    din = 1'b0; din_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    idle(2);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_msg", int'(out_msg), 0);
    chk("rst_flags", int'({out_par_err, out_frm_err}), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk_err_count();
    rst = 1'b0;
    idle(2);

    // good frame: out_valid one cycle after stop, one-cycle pulse
    push(4'b1011, 1'b0, 1'b0);
    send_frame(7'b0_1011_1_1, 0, 1'b1, 1'b0);
    chk("t1_latency", int'(out_valid), 1);
    idle(1);
    chk("t1_pulse", int'(out_valid), 0);

    // parity error
    push(4'b1100, 1'b1, 1'b0);
    send_frame(7'b0_1100_1_1, 0, 1'b1, 1'b0);
    chk("t2_valid", int'(out_valid), 1);
    idle(2);

    // stalls and framing error
    push(4'b0001, 1'b0, 1'b1);
    send_frame(7'b0_0001_1_0, 3, 1'b1, 1'b0);
    chk("t3_valid", int'(out_valid), 1);
    idle(2);

    // backpressure and overrun
    out_ready = 1'b0;
    push(4'b0011, 1'b0, 1'b0);
    send_frame(7'b0_0011_0_1, 0, 1'b1, 1'b0);
    chk("t4_valid_first", int'(out_valid), 1);
    chk("t4_no_overrun_yet", int'(overrun), 0);
    send_frame(7'b0_0101_0_1, 0, 1'b0, 1'b0);
    chk("t4_overrun", int'(overrun), 1);
    idle(3);
    chk("t4_held_msg", int'(out_msg), 4'b0011);
    chk("t4_held_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    idle(1);
    chk("t4_drained", int'(out_valid), 0);
    idle(2);
    chk("t4_overrun_sticky", int'(overrun), 1);

    // reset mid-frame, after the 2nd data bit
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    idle(1);
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_msg", int'(out_msg), 0);
    chk("t5_rst_flags", int'({out_par_err, out_frm_err}), 0);
    chk("t5_rst_overrun", int'(overrun), 0);
    exp_err = 0;
    chk_err_count();
    rst = 1'b0;
    push(4'b1111, 1'b0, 1'b0);
    send_frame(7'b0_1111_0_1, 0, 1'b1, 1'b0);
    chk("t5_valid", int'(out_valid), 1);
    idle(2);

    // simultaneous drain and load
    out_ready = 1'b0;
    push(4'b0110, 1'b0, 1'b0);
    send_frame(7'b0_0110_0_1, 0, 1'b1, 1'b0);
    push(4'b1001, 1'b0, 1'b0);
    send_frame(7'b0_1001_0_1, 0, 1'b0, 1'b1);
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_msg", int'(out_msg), 4'b1001);
    chk("t6_overrun", int'(overrun), 0);
    idle(2);
    chk("t6_drained", int'(out_valid), 0);

    // bad frames back to back (counter saturation when enabled)
    out_ready = 1'b1;
    push(4'b1000, 1'b1, 1'b0);
    send_frame(7'b0_1000_0_1, 0, 1'b1, 1'b0);
    push(4'b0000, 1'b0, 1'b1);
    send_frame(7'b0_0000_0_0, 0, 1'b1, 1'b0);
    push(4'b0111, 1'b0, 1'b1);
    send_frame(7'b0_0111_1_0, 0, 1'b1, 1'b0);
    push(4'b0010, 1'b1, 1'b0);
    send_frame(7'b0_0010_0_1, 0, 1'b1, 1'b0);
    push(4'b1110, 1'b0, 1'b0);
    send_frame(7'b0_1110_1_1, 0, 1'b1, 1'b0);
    push(4'b0100, 1'b1, 1'b1);
    send_frame(7'b0_0100_0_0, 0, 1'b1, 1'b0);
    idle(3);
    chk("final_overrun", int'(overrun), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive-side counterpart of the 4-bit even-parity generator.
- Deserialises a framed serial stream carrying 4 message bits plus their even-parity bit, checks parity and framing, and presents the recovered nibble on a valid/ready output with error flags.
- Sits between a serial link and downstream consumer logic.

Parameters:
- CNT_W, 8, width of the saturating error counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only in cycles where this is high; low means stall.
- out_msg  output  4  recovered message {A,B,C,D}, A = first data bit received.
- out_par_err  output  1  parity error for out_msg.
- out_frm_err  output  1  stop bit was 0 for out_msg.
- out_valid  output  1  out_msg and the flags are valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- overrun  output  1  sticky; a completed frame was dropped because the holding register was full.
- err_count  output  CNT_W  saturating count of frames with parity or framing error (optional feature only).

Behaviour:
- Frame, one bit per din_valid cycle, in order:
  - start bit (0)
  - A, B, C, D
  - parity P
  - stop bit (1)
- FSM states:
  - IDLE: din_valid && din==0 -> DATA with bit index 0. din==1 or !din_valid -> stay.
  - DATA: on each din_valid, shift the bit in. After the 4th bit -> PARITY.
  - PARITY: on din_valid, latch P -> STOP.
  - STOP: on din_valid, the frame is complete -> IDLE.
- In all states, din_valid low holds the state and all registers.
- Parity check: par_err = A^B^C^D^P. Even parity means 0 is good.
- Frame error: frm_err = ~stop_bit. A frame with a frame error is still delivered with out_frm_err=1.
- Latency: out_valid rises on the cycle after the stop bit is sampled.
- Holding register, one entry:
  - Loaded at frame completion when it is empty, or when it is being drained in that same cycle (out_valid && out_ready). Simultaneous drain and load gives no gap and no overrun.
  - Frame completes while out_valid=1 and out_ready=0: the new frame is discarded, the held data is unchanged, and overrun is set to 1 from the next cycle. overrun clears only on rst.
- out_msg and the flags are stable while out_valid && !out_ready.
- A back-to-back start bit is accepted in the cycle immediately after the stop bit.
- Reset (any cycle, including mid-frame), values visible after the reset edge:
  - FSM = IDLE, shift register = 0, out_valid = 0, out_msg = 0, out_par_err = 0, out_frm_err = 0, overrun = 0, err_count = 0.
  - Any partial frame is discarded.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_count increments by 1 for each completed frame with par_err|frm_err, including frames dropped by overrun. It saturates at 2^CNT_W-1 and does not wrap. It resets to 0.
- Undefined: the err_count port is still present but tied to 0, and no counter logic is built.

Test Plan:
- Good frame: stream 0,1,0,1,1,1,1 (msg 1011, P=1), out_ready=1 -> out_valid pulses for 1 cycle, one cycle after the stop bit, with out_msg=4'b1011, par_err=0, frm_err=0.
- Parity error: stream 0,1,1,0,0,1,1 (msg 1100, P=1) -> out_msg=4'b1100, out_par_err=1. With PARITY_ERR_CNT_EN, err_count=1.
- Stalls and framing error: stream 0,0,0,0,1,1,0 with din_valid low for 3 cycles between each bit -> out_msg=4'b0001, par_err=0, frm_err=1, and no early out_valid.
- Backpressure and overrun: out_ready=0, two back-to-back good frames 0011 and 0101 (P=0 each) -> out_msg stays 0011, overrun=1. Then out_ready=1 -> a single transfer of 0011.
- Simultaneous drain and load: out_ready asserted in exactly the cycle the second frame's stop bit completes -> both frames are delivered in order and overrun stays 0.
- Reset mid-frame: assert rst after the 2nd data bit -> next cycle shows IDLE, out_valid=0 and all outputs 0. A following good frame 1111 (P=0) is received correctly. For the saturation check, set CNT_W=2 and send 5 bad frames -> err_count=3.
